// File: rtl/conv_ctrl_pkg.sv
// rtl/conv_ctrl_pkg.sv - shared types, constants and sizing helper for layer sequencers
package conv_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } seq_state_e;

   localparam int unsigned WADDR_W = 32;

   // Counter width needed to hold values 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/conv_watchdog.sv
// rtl/conv_watchdog.sv - run-phase cycle watchdog with single-cycle expire indication
module conv_watchdog
#(
   parameter int unsigned pCNT_W = 8
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              enable,
   input  logic [pCNT_W-1:0] limit,
   output logic              expire
);

   logic [pCNT_W-1:0] cnt_q, cnt_d;

   // Clear wins over counting; a zero limit leaves the counter free-running but never expires.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = enable && (limit != '0) && (cnt_q == limit - 1'b1);

endmodule

// File: rtl/conv_layer_sequencer.sv
// rtl/conv_layer_sequencer.sv - loads one layer of weights into a conv kernel RAM, then runs the conv
module conv_layer_sequencer
   import conv_ctrl_pkg::*;
#(
   parameter int unsigned          pWEIGHT_DATA_WIDTH = 64,
   parameter logic [WADDR_W-1:0]   pWEIGHT_BASE_ADDR  = '0,
   parameter int unsigned          pWEIGHT_WORDS      = 36,
   parameter int unsigned          pTIMEOUT_CYCLES    = 0
)
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          cfg_skip_load,
   input  logic                          abort,
   input  logic [pWEIGHT_DATA_WIDTH-1:0] s_wdata,
   input  logic                          s_wvalid,
   output logic                          s_wready,
   output logic                          conv_load_weight,
   output logic [WADDR_W-1:0]            conv_weight_addr,
   output logic [pWEIGHT_DATA_WIDTH-1:0] conv_weight_data,
   output logic                          conv_en,
   input  logic                          conv_done,
   output logic                          busy,
   output logic                          layer_done,
   output logic                          timeout_err
);

   localparam int unsigned IDX_W = cnt_width(pWEIGHT_WORDS);
   localparam int unsigned WD_W  = cnt_width(pTIMEOUT_CYCLES + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(pWEIGHT_WORDS - 1);
   localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(pTIMEOUT_CYCLES);

   if (pWEIGHT_WORDS < 1) begin : g_bad_words
      $error("conv_layer_sequencer: pWEIGHT_WORDS must be at least 1");
   end
   if ((64'(pWEIGHT_BASE_ADDR) + 64'(pWEIGHT_WORDS) - 64'd1) > 64'h0000_0000_FFFF_FFFF) begin : g_bad_addr
      $error("conv_layer_sequencer: weight address range exceeds 32 bits");
   end

   seq_state_e                    state_q, state_d;
   logic [IDX_W-1:0]              idx_q, idx_d;
   logic                          loaded_q, loaded_d;
   logic                          load_q, load_d;
   logic [WADDR_W-1:0]            addr_q, addr_d;
   logic [pWEIGHT_DATA_WIDTH-1:0] data_q, data_d;
   logic                          en_q, en_d;
   logic                          busy_q, busy_d;
   logic                          layer_done_q, layer_done_d;
   logic                          timeout_err_q, timeout_err_d;
   logic                          wd_clear, wd_enable, wd_expire;

   // Next-state and output decode; exit priority in RUN is abort, then conv_done, then watchdog.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      loaded_d      = loaded_q;
      load_d        = 1'b0;
      addr_d        = addr_q;
      data_d        = data_q;
      en_d          = 1'b0;
      layer_done_d  = 1'b0;
      timeout_err_d = 1'b0;
      s_wready      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               if (cfg_skip_load && loaded_q) begin
                  state_d = ST_RUN;
               end else begin
                  // Overwriting the kernel RAM makes any earlier weights stale.
                  state_d  = ST_LOAD;
                  idx_d    = '0;
                  loaded_d = 1'b0;
               end
            end
         end
         ST_LOAD: begin
            s_wready = !abort;
            if (abort) begin
               state_d  = ST_IDLE;
               loaded_d = 1'b0;
            end else if (s_wvalid) begin
               load_d = 1'b1;
               addr_d = pWEIGHT_BASE_ADDR + WADDR_W'(idx_q);
               data_d = s_wdata;
               idx_d  = idx_q + 1'b1;
               if (idx_q == LAST_IDX) begin
                  loaded_d = 1'b1;
                  state_d  = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d  = ST_IDLE;
               loaded_d = 1'b0;
            end else if (conv_done && en_q) begin
               state_d      = ST_IDLE;
               layer_done_d = 1'b1;
            end else if (wd_expire) begin
               state_d       = ST_IDLE;
               timeout_err_d = 1'b1;
               loaded_d      = 1'b0;
            end else begin
               en_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         loaded_q      <= 1'b0;
         load_q        <= 1'b0;
         addr_q        <= '0;
         data_q        <= '0;
         en_q          <= 1'b0;
         busy_q        <= 1'b0;
         layer_done_q  <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         loaded_q      <= loaded_d;
         load_q        <= load_d;
         addr_q        <= addr_d;
         data_q        <= data_d;
         en_q          <= en_d;
         busy_q        <= busy_d;
         layer_done_q  <= layer_done_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign wd_clear  = (state_q != ST_RUN) && (state_d == ST_RUN);
   assign wd_enable = (state_q == ST_RUN);

   conv_watchdog #(
      .pCNT_W (WD_W)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .clear  (wd_clear),
      .enable (wd_enable),
      .limit  (WD_LIMIT),
      .expire (wd_expire)
   );

   assign conv_load_weight = load_q;
   assign conv_weight_addr = addr_q;
   assign conv_weight_data = data_q;
   assign conv_en          = en_q;
   assign busy             = busy_q;
   assign layer_done       = layer_done_q;
   assign timeout_err      = timeout_err_q;

endmodule

// File: doc/conv_layer_sequencer.md
Name: conv_layer_sequencer

Overview:
Per-layer controller that sits in front of one conv instance and sequences a full layer.
On a start pulse it streams the layer's weight words from a valid/ready source into the conv kernel RAM port (load_weight/weight_addr/weight_data). It then holds the conv enable until the conv reports done, and returns to idle.
It supports weight reuse across frames (skip load), abort, and a run watchdog.

Parameters:
pWEIGHT_DATA_WIDTH, 64, width of one weight word (matches conv weight port)
pWEIGHT_BASE_ADDR, 0, first kernel-RAM address written for this layer
pWEIGHT_WORDS, 36, weight words per layer; legal range is >= 1
pTIMEOUT_CYCLES, 0, max cycles in RUN before timeout; 0 disables the watchdog

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request to run one layer
cfg_skip_load  in  1  sampled with start; reuse loaded weights if valid
abort  in  1  cancel current load/run
s_wdata  in  pWEIGHT_DATA_WIDTH  weight stream data
s_wvalid  in  1  weight stream valid
s_wready  out  1  weight stream ready
conv_load_weight  out  1  kernel RAM write strobe
conv_weight_addr  out  32  kernel RAM write address
conv_weight_data  out  pWEIGHT_DATA_WIDTH  kernel RAM write data
conv_en  out  1  conv enable (level)
conv_done  in  1  conv frame-complete pulse
busy  out  1  state != IDLE
layer_done  out  1  one-cycle pulse on successful completion
timeout_err  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset:
  - state = IDLE; index, watchdog and weights_loaded = 0.
  - All outputs are 0, including conv_weight_addr and conv_weight_data.
- States:
  - IDLE
  - LOAD
  - RUN
- IDLE:
  - s_wready = 0.
  - start=1 and abort=0:
    - cfg_skip_load=1 and weights_loaded=1 → RUN next cycle.
    - Otherwise → LOAD next cycle, index = 0.
  - start and abort together in IDLE: start is ignored.
- LOAD:
  - s_wready = 1; it is combinational from state and is also 0 when abort=1.
  - A transfer occurs on s_wvalid && s_wready.
  - Each transfer produces a registered write in the next cycle:
    - conv_load_weight = 1
    - conv_weight_addr = pWEIGHT_BASE_ADDR + index
    - conv_weight_data = s_wdata
    - index increments.
  - conv_load_weight is 0 in all other cycles. Address/data hold their last value.
  - s_wvalid gaps insert idle cycles, with no write.
  - On the transfer with index = pWEIGHT_WORDS-1: weights_loaded ← 1 and state → RUN.
  - The last write strobe coincides with the first RUN cycle T.
- RUN:
  - conv_en is registered. It goes to 1 at cycle T+1 (entry from LOAD) or at the cycle after RUN entry (skip path), and holds 1.
  - The watchdog clears on RUN entry and increments each RUN cycle.
  - conv_done=1 while conv_en=1:
    - Next cycle: conv_en = 0, layer_done = 1 for one cycle, state = IDLE.
    - weights_loaded is kept.
  - conv_done while conv_en=0 is ignored.
  - pTIMEOUT_CYCLES != 0 and watchdog == pTIMEOUT_CYCLES-1 with no conv_done:
    - Next cycle: timeout_err = 1 for one cycle, conv_en = 0, state = IDLE, weights_loaded = 0.
- Abort (LOAD or RUN):
  - Next cycle: state = IDLE, conv_en = 0, no layer_done, weights_loaded = 0.
  - In LOAD, no transfer is accepted in the abort cycle.
- Priority in one cycle: rst > abort > conv_done > timeout.
- start while busy=1 is ignored; requests are not queued.
- Minimum gap: conv_en is low for ≥1 cycle between consecutive layers, so the conv controller restarts cleanly.
- busy is registered and equals (state != IDLE).
- Reset mid-load or mid-run: immediate return to reset values next edge. Partial weights are considered invalid.
- Address arithmetic is 32-bit unsigned. pWEIGHT_BASE_ADDR + pWEIGHT_WORDS - 1 must fit in 32 bits; this is checked by elaboration assertion.

Decomposition:
- Shared package conv_ctrl_pkg holds:
  - the state enum typedef (IDLE/LOAD/RUN);
  - the 32-bit weight-address width constant;
  - a function returning $clog2 of word/timeout counts for counter sizing.
- One natural sub-module: conv_watchdog. It provides clear/enable/limit inputs and an expire pulse, is bypassed when the limit is 0, and is reusable by pooling/FC sequencers.

Test Plan:
1. Full load, pWEIGHT_WORDS=4, base=16:
   - Stimulus: start, then s_wvalid continuous with data 0xA..0xD.
   - Required: writes at addr 16,17,18,19 with matching data on 4 consecutive cycles; conv_en rises the cycle after the 4th write.
   - Then conv_done pulse → conv_en falls next cycle with layer_done=1.
2. Backpressured load:
   - Stimulus: s_wvalid toggles 1,0,0,1,1,0,1.
   - Required: exactly 4 write strobes with contiguous addresses, no write in the gap cycles, busy=1 throughout.
3. Skip load:
   - Stimulus: after scenario 1, start with cfg_skip_load=1.
   - Required: no s_wready, conv_en=1 two cycles after start.
   - Then: after an abort, start with skip=1 → full LOAD occurs.
4. Timeout, pTIMEOUT_CYCLES=10:
   - Stimulus: no conv_done.
   - Required: timeout_err pulse exactly 10 cycles after RUN entry, conv_en=0 and busy=0 the same cycle.
   - Required: conv_done together with timeout expiry → layer_done only.
5. Abort mid-load:
   - Stimulus: abort after 2 of 4 words.
   - Required: next cycle busy=0, no further writes; the abort cycle has s_wready=0.
   - Required: start in the same cycle as abort in IDLE is ignored.
6. Reset during RUN:
   - Stimulus: rst asserted.
   - Required: next edge conv_en=0, all outputs 0.
   - Required: start while busy is ignored (no second layer_done).
